// File: rtl/clk_rst_sequencer.sv
// Clock-ready and reset sequencer.
// Qualifies PLL lock flags, debounces the active-low start key, and then
// releases the per-domain resets one stage at a time. Any loss of lock
// during release or run forces every domain back into reset and restarts
// the sequence.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_LOCK  | all domains in reset, waiting for qualified lock
// WAIT_START | locks good, waiting for a recorded start press
// RELEASE    | releasing domains bit 0 upward, STAGE_GAP cycles apart
// RUN        | every domain released, done high
// FAULT      | one cycle: lock lost, all domains re-reset, loss counted
module clk_rst_sequencer #(
    parameter int                     NUM_LOCK       = 2,
    parameter logic [NUM_LOCK-1:0]    LOCK_MASK      = '1,
    parameter int                     LOCK_STABLE    = 1024,
    parameter int                     START_DEBOUNCE = 16,
    parameter int                     NUM_DOM        = 3,
    parameter int                     STAGE_GAP      = 8,
    parameter int                     AUTO_START     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LOCK-1:0] lock_in,
    input  logic                start_n,
    output logic [NUM_DOM-1:0]  rst_dom,
    output logic                done,
    output logic                all_locked,
    output logic [2:0]          seq_state,
    output logic [7:0]          lock_lost_cnt
);

    localparam int STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int DEB_W  = $clog2(START_DEBOUNCE + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);

    localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(LOCK_STABLE);
    localparam logic [DEB_W-1:0]  DEB_MAX    = DEB_W'(START_DEBOUNCE);
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        WAIT_START = 3'd1,
        RELEASE    = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    state_t               state;
    logic [NUM_LOCK-1:0]  lock_meta;
    logic [NUM_LOCK-1:0]  lock_sync;
    logic                 start_meta;
    logic                 start_sync;
    logic                 ml;
    logic [STAB_W-1:0]    stab_cnt;
    logic [DEB_W-1:0]     deb_cnt;
    logic [DEB_W-1:0]     deb_next;
    logic                 start_seen;
    logic                 start_ok;
    logic [GAP_W-1:0]     gap_cnt;

    // Double-flop synchronisers for the asynchronous lock flags and start key
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta  <= '0;
            lock_sync  <= '0;
            start_meta <= 1'b0;
            start_sync <= 1'b0;
        end else begin
            lock_meta  <= lock_in;
            lock_sync  <= lock_meta;
            start_meta <= start_n;
            start_sync <= start_meta;
        end
    end

    // Masked-off lock inputs always read as locked
    assign ml = &(lock_sync | ~LOCK_MASK);

    // Lock qualification: saturating run-length of masked lock, cleared on any drop.
    // all_locked also gates on ml so a drop is seen one cycle after the sync stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            stab_cnt   <= '0;
            all_locked <= 1'b0;
        end else begin
            if (!ml)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 1'b1;
            all_locked <= ml && (stab_cnt == STAB_MAX);
        end
    end

    // Next value of the saturating low-level run counter for the start key
    always_comb begin
        deb_next = deb_cnt;
        if (start_sync)
            deb_next = '0;
        else if (deb_cnt != DEB_MAX)
            deb_next = deb_cnt + 1'b1;
    end

    // Start press latch: sticky until reset, survives lock loss
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt    <= '0;
            start_seen <= 1'b0;
        end else begin
            deb_cnt <= deb_next;
            if (deb_next == DEB_MAX)
                start_seen <= 1'b1;
        end
    end

    assign start_ok = start_seen || (AUTO_START != 0);

    // Sequencing FSM; rst_dom shifts zeros in from bit 0 so releases stay monotonic
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_LOCK;
            rst_dom       <= '1;
            done          <= 1'b0;
            gap_cnt       <= '0;
            lock_lost_cnt <= 8'd0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (all_locked)
                        state <= WAIT_START;
                end
                WAIT_START: begin
                    if (!all_locked) begin
                        state <= WAIT_LOCK;
                    end else if (start_ok) begin
                        state   <= RELEASE;
                        rst_dom <= rst_dom << 1;
                        gap_cnt <= GAP_RELOAD;
                    end
                end
                RELEASE: begin
                    if (!all_locked) begin
                        state   <= FAULT;
                        rst_dom <= '1;
                        done    <= 1'b0;
                        if (lock_lost_cnt != 8'hFF)
                            lock_lost_cnt <= lock_lost_cnt + 8'd1;
                    end else if (rst_dom == '0) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        rst_dom <= rst_dom << 1;
                        gap_cnt <= GAP_RELOAD;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (!all_locked) begin
                        state   <= FAULT;
                        rst_dom <= '1;
                        done    <= 1'b0;
                        if (lock_lost_cnt != 8'hFF)
                            lock_lost_cnt <= lock_lost_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    state <= WAIT_LOCK;
                end
                default: begin
                    state   <= WAIT_LOCK;
                    rst_dom <= '1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign seq_state = state;

endmodule

// File: doc/clk_rst_sequencer.md
# clk_rst_sequencer

Parametrised clock-ready and reset sequencer for the processor's clock-management layer. It qualifies any number of PLL lock indications, debounces the active-low start key, and releases a set of per-domain resets one stage at a time. It asserts `done` only when the whole system is up. Any loss of lock re-asserts every domain reset and restarts the sequence automatically. The block runs entirely in the always-on reference clock domain.

## Interface
Parameters:
- `NUM_LOCK`, 2: number of PLL lock inputs.
- `LOCK_MASK`, all ones (NUM_LOCK bits): bit k = 0 ignores `lock_in[k]`. Used for simulation without the PHY clock.
- `LOCK_STABLE`, 1024: consecutive all-locked cycles required before locks count as good (≥1).
- `START_DEBOUNCE`, 16: consecutive low cycles of synchronised `start_n` required to register a press (≥1).
- `NUM_DOM`, 3: number of reset domains released in sequence (≥1).
- `STAGE_GAP`, 8: cycles between successive domain releases (≥1).
- `AUTO_START`, 0: when 1, no start press is needed.

Ports:
- `clk` in 1: reference clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `lock_in` in NUM_LOCK: PLL locked flags; asynchronous, each double-flop synchronised.
- `start_n` in 1: start key, active-low, asynchronous; double-flop synchronised.
- `rst_dom` out NUM_DOM: per-domain reset, active-high. Bit 0 is released first.
- `done` out 1: high only in state RUN.
- `all_locked` out 1: qualified lock status.
- `seq_state` out 3: encoding is WAIT_LOCK=0, WAIT_START=1, RELEASE=2, RUN=3, FAULT=4.
- `lock_lost_cnt` out 8: count of lock losses while in RELEASE or RUN; saturates at 255.

## Operation
- Masked lock: `ml = &(lock_sync | ~LOCK_MASK)`.
- Stable counter:
  - Increments while `ml` = 1 and saturates at LOCK_STABLE.
  - Clears to 0 in the same cycle `ml` = 0.
  - `all_locked` = (counter == LOCK_STABLE), registered.
- Start flag:
  - A debounce counter counts cycles with `start_sync` = 0 and clears when `start_sync` = 1.
  - When the counter reaches START_DEBOUNCE, `start_seen` sets.
  - `start_seen` is sticky until `reset` and is not cleared by lock loss.
  - AUTO_START=1 forces `start_seen` = 1.
- State machine:
  - WAIT_LOCK → WAIT_START when `all_locked`.
  - WAIT_START → RELEASE when `start_seen`; → WAIT_LOCK if `all_locked` drops.
  - RELEASE: stage counter s starts at 0 on entry.
    - `rst_dom[0]` deasserts in the first RELEASE cycle.
    - `rst_dom[k]` deasserts k×STAGE_GAP cycles after entry.
    - The cycle after `rst_dom[NUM_DOM-1]` deasserts, go to RUN.
  - RUN: all `rst_dom` = 0, `done` = 1.
  - RELEASE or RUN with `all_locked` = 0 → FAULT.
  - FAULT lasts exactly one cycle:
    - All `rst_dom` = 1 and `done` = 0.
    - `lock_lost_cnt` increments (saturating) once.
    - Next state is WAIT_LOCK.
- Released domains stay released in RELEASE; `rst_dom` is monotonic within one sequence.

## Timing
- Reset values:
  - `rst_dom` = all ones, `done` = 0, `all_locked` = 0.
  - `seq_state` = WAIT_LOCK, `lock_lost_cnt` = 0.
  - All counters, synchronisers and `start_seen` = 0.
- `lock_in` rising → `ml` high after 2 cycles → `all_locked` high LOCK_STABLE+1 cycles after that.
- `lock_in` falling → `all_locked` low 3 cycles later: 2 for sync, 1 for register.
- Entry into RELEASE is the cycle after `all_locked` & `start_seen` are both true in WAIT_START.
- RELEASE duration is (NUM_DOM-1)×STAGE_GAP+1 cycles. `done` rises the cycle after that.
- Simultaneous events:
  - Lock loss in the same cycle as a stage release or the RUN transition: FAULT wins and no further domain is released.
  - A start press during WAIT_LOCK is recorded and consumed later.
  - `reset` mid-sequence returns all outputs to reset values on the next edge, and clears `start_seen`.
- LOCK_MASK all zero: `all_locked` rises LOCK_STABLE+1 cycles after reset release, regardless of `lock_in`.

## Test plan
1. Cold start (defaults, AUTO_START=0):
   - Stimulus: both locks high at t0, `start_n` low for 16 cycles at t0+2000.
   - Required: `all_locked` high at t0+1027; RELEASE entered; `rst_dom` bits drop at offsets 0, 8 and 16 cycles; `done` high at offset 17.
2. Debounce:
   - Stimulus: `start_n` low pulses of 15 cycles.
   - Required: never leaves WAIT_START. A 16-cycle pulse starts RELEASE.
3. Lock loss in RUN:
   - Stimulus: drop `lock_in[1]` for 5 cycles.
   - Required: one FAULT cycle with all `rst_dom` = 1; `lock_lost_cnt` = 1. On relock, the sequence reruns with no new start press.
4. Lock glitch during qualification:
   - Stimulus: a 1-cycle `lock_in[0]` drop at stable count 500.
   - Required: counter restarts; `all_locked` is delayed by the full LOCK_STABLE.
5. Masking:
   - Stimulus: LOCK_MASK=2'b01 with `lock_in[1]` held 0.
   - Required: the sequence completes normally.
6. Mid-sequence events:
   - Stimulus: `reset` asserted during RELEASE after domain 1 is released.
   - Required: all `rst_dom` = 1 next cycle and `start_seen` cleared; a new press is required.
   - Stimulus: 300 lock losses.
   - Required: `lock_lost_cnt` holds at 255.
